// File: rtl/hs_sync_aligner.sv
// C-PHY HS receive front end: finds preamble + sync word, then forwards payload
// symbols word-aligned to the deserializer and pads to a word boundary at burst end.
//
// state    | meaning
// IDLE     | waiting for the first preamble symbol (3)
// PREAMBLE | counting consecutive 3s
// SYNC     | matching the remainder of the sync word 3444443
// DATA     | forwarding payload symbols to the deserializer
// FLUSH    | padding zero symbols until WordPhase wraps to 0
module hs_sync_aligner #(
  parameter int PRE_MIN   = 7,
  parameter int PRE_CNT_W = 4
) (
  input  logic       RxSymClkHS,
  input  logic       RstN,
  input  logic [2:0] RxSymIn,
  input  logic       RxSymValid,
  input  logic       HSRxEn,
  output logic [2:0] SerSym,
  output logic       HSDeserEn,
  output logic       SyncDetected,
  output logic       SyncErr,
  output logic       RxActiveHS,
  output logic [2:0] WordPhase
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] PREAMBLE = 3'd1;
  localparam logic [2:0] SYNC     = 3'd2;
  localparam logic [2:0] DATA     = 3'd3;
  localparam logic [2:0] FLUSH    = 3'd4;

  localparam logic [2:0] SYM3 = 3'b011;
  localparam logic [2:0] SYM4 = 3'b100;

  logic [2:0]           r_state, w_state;
  logic [PRE_CNT_W-1:0] r_cnt, w_cnt;
  logic [2:0]           r_idx, w_idx;
  logic [2:0]           r_ser, w_ser;
  logic                 r_en, w_en;
  logic                 r_det, w_det;
  logic                 r_err, w_err;
  logic                 r_act, w_act;
  logic [2:0]           r_wp, w_wp;
  logic [2:0]           w_wp_inc;
  logic [2:0]           w_pos;
  logic [2:0]           w_exp;

  assign w_wp_inc = (r_wp == 3'd6) ? 3'd0 : r_wp + 3'd1;
  // r_idx is the last matched sync position; the incoming symbol is position r_idx+1
  assign w_pos    = r_idx + 3'd1;
  assign w_exp    = (w_pos == 3'd6) ? SYM3 : SYM4;

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_idx   = r_idx;
    w_ser   = r_ser;
    w_en    = 1'b0;
    w_det   = 1'b0;
    w_err   = 1'b0;
    w_wp    = r_wp;
    case (r_state)
      IDLE: begin
        w_cnt = '0;
        w_idx = 3'd0;
        w_wp  = 3'd0;
        if (HSRxEn && RxSymValid && RxSymIn == SYM3) begin
          w_state = PREAMBLE;
          w_cnt   = PRE_CNT_W'(1);
        end
      end
      PREAMBLE: begin
        if (!HSRxEn) begin
          w_state = IDLE;
          w_cnt   = '0;
        end else if (RxSymValid) begin
          if (RxSymIn == SYM3) begin
            w_cnt = (r_cnt == {PRE_CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
          end else if (RxSymIn == SYM4 && r_cnt >= PRE_CNT_W'(PRE_MIN)) begin
            w_state = SYNC;
            w_idx   = 3'd1;
            w_cnt   = '0;
          end else begin
            w_state = IDLE;
            w_cnt   = '0;
          end
        end
      end
      SYNC: begin
        if (!HSRxEn) begin
          w_state = IDLE;
          w_idx   = 3'd0;
        end else if (RxSymValid) begin
          if (RxSymIn == w_exp) begin
            if (w_pos == 3'd6) begin
              w_state = DATA;
              w_det   = 1'b1;
              w_wp    = 3'd0;
              w_idx   = 3'd0;
            end else begin
              w_idx = w_pos;
            end
          end else begin
            w_state = IDLE;
            w_err   = 1'b1;
            w_idx   = 3'd0;
          end
        end
      end
      DATA: begin
        if (!HSRxEn) begin
          w_state = (r_wp == 3'd0) ? IDLE : FLUSH;
        end else if (RxSymValid) begin
          w_ser = RxSymIn;
          w_en  = 1'b1;
          w_wp  = w_wp_inc;
        end
      end
      FLUSH: begin
        w_ser = 3'd0;
        w_en  = 1'b1;
        w_wp  = w_wp_inc;
        if (w_wp_inc == 3'd0) w_state = IDLE;
      end
      default: begin
        w_state = IDLE;
        w_cnt   = '0;
        w_idx   = 3'd0;
        w_wp    = 3'd0;
      end
    endcase
    w_act = (w_state == DATA) || (w_state == FLUSH);
  end

  always_ff @(posedge RxSymClkHS or negedge RstN) begin
    if (!RstN) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_ser   <= 3'd0;
      r_en    <= 1'b0;
      r_det   <= 1'b0;
      r_err   <= 1'b0;
      r_act   <= 1'b0;
      r_wp    <= 3'd0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_ser   <= w_ser;
      r_en    <= w_en;
      r_det   <= w_det;
      r_err   <= w_err;
      r_act   <= w_act;
      r_wp    <= w_wp;
    end
  end

  assign SerSym       = r_ser;
  assign HSDeserEn    = r_en;
  assign SyncDetected = r_det;
  assign SyncErr      = r_err;
  assign RxActiveHS   = r_act;
  assign WordPhase    = r_wp;

endmodule

// File: tb/tb_hs_sync_aligner.sv
// Directed bench for hs_sync_aligner: lock, data forwarding, preamble/sync errors,
// flush padding, valid gaps and mid-burst reset.
module tb_hs_sync_aligner;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] sym;
  logic       vld;
  logic       hsen;
  logic [2:0] ser_sym;
  logic       deser_en;
  logic       sync_det;
  logic       sync_err;
  logic       active;
  logic [2:0] word_phase;

  int checks = 0;
  int errors = 0;

  hs_sync_aligner #(.PRE_MIN(7), .PRE_CNT_W(4)) dut (
    .RxSymClkHS  (clk),
    .RstN        (rst_n),
    .RxSymIn     (sym),
    .RxSymValid  (vld),
    .HSRxEn      (hsen),
    .SerSym      (ser_sym),
    .HSDeserEn   (deser_en),
    .SyncDetected(sync_det),
    .SyncErr     (sync_err),
    .RxActiveHS  (active),
    .WordPhase   (word_phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [2:0] s, input logic v, input logic e);
    sym  = s;
    vld  = v;
    hsen = e;
    @(posedge clk);
    #1;
  endtask

  task automatic send_pre(input int n);
    for (int i = 0; i < n; i++) step(3'd3, 1'b1, 1'b1);
  endtask

  task automatic lock(input string tag);
    send_pre(7);
    for (int i = 0; i < 5; i++) step(3'd4, 1'b1, 1'b1);
    chk({tag, "_det_before"}, sync_det, 0);
    chk({tag, "_en_before"}, deser_en, 0);
    step(3'd3, 1'b1, 1'b1);
    chk({tag, "_det"}, sync_det, 1);
    chk({tag, "_err"}, sync_err, 0);
    chk({tag, "_act"}, active, 1);
    chk({tag, "_wp"}, word_phase, 0);
    chk({tag, "_en"}, deser_en, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    sym   = 3'd0;
    vld   = 1'b0;
    hsen  = 1'b0;
    #12;
    chk("rst_ser", ser_sym, 0);
    chk("rst_en", deser_en, 0);
    chk("rst_det", sync_det, 0);
    chk("rst_err", sync_err, 0);
    chk("rst_act", active, 0);
    chk("rst_wp", word_phase, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic lock and 14 data symbols
    lock("t1");
    for (int i = 0; i < 14; i++) begin
      step(3'(i % 7), 1'b1, 1'b1);
      chk("t1_en", deser_en, 1);
      chk("t1_ser", ser_sym, 8'(i % 7));
      chk("t1_wp", word_phase, 8'((i + 1) % 7));
      chk("t1_det_low", sync_det, 0);
    end
    step(3'd0, 1'b0, 1'b0);
    chk("t1_end_act", active, 0);
    chk("t1_end_en", deser_en, 0);

    // final sync symbol coincides with HSRxEn fall
    send_pre(7);
    for (int i = 0; i < 5; i++) step(3'd4, 1'b1, 1'b1);
    step(3'd3, 1'b1, 1'b0);
    chk("coinc_det", sync_det, 0);
    chk("coinc_act", active, 0);
    chk("coinc_err", sync_err, 0);
    step(3'd0, 1'b0, 1'b1);
    chk("coinc_idle_act", active, 0);

    // short preamble
    send_pre(5);
    step(3'd4, 1'b1, 1'b1);
    chk("t2_err", sync_err, 0);
    chk("t2_en", deser_en, 0);
    chk("t2_act", active, 0);
    step(3'd4, 1'b1, 1'b1);
    chk("t2_err2", sync_err, 0);
    lock("t2");
    step(3'd0, 1'b0, 1'b0);
    chk("t2_end_act", active, 0);

    // corrupted sync word
    send_pre(8);
    step(3'd4, 1'b1, 1'b1);
    step(3'd4, 1'b1, 1'b1);
    step(3'd2, 1'b1, 1'b1);
    chk("t3_err", sync_err, 1);
    chk("t3_det", sync_det, 0);
    chk("t3_act", active, 0);
    chk("t3_en", deser_en, 0);
    step(3'd0, 1'b0, 1'b1);
    chk("t3_err_pulse", sync_err, 0);
    lock("t3");

    // 10 data symbols then burst end at WordPhase 3 -> 4 pads
    for (int i = 0; i < 10; i++) step(3'(i % 7), 1'b1, 1'b1);
    chk("t4_wp", word_phase, 3);
    chk("t4_ser", ser_sym, 2);
    step(3'd5, 1'b1, 1'b0);
    chk("t4_drop_en", deser_en, 0);
    chk("t4_drop_wp", word_phase, 3);
    chk("t4_drop_act", active, 1);
    for (int k = 0; k < 4; k++) begin
      step(3'd5, 1'b1, 1'b1);
      chk("t4_pad_en", deser_en, 1);
      chk("t4_pad_ser", ser_sym, 0);
      chk("t4_pad_wp", word_phase, 8'((4 + k) % 7));
      chk("t4_pad_act", active, (k < 3) ? 8'd1 : 8'd0);
    end
    step(3'd5, 1'b1, 1'b1);
    chk("t4_post_en", deser_en, 0);
    chk("t4_post_act", active, 0);
    chk("t4_post_wp", word_phase, 0);

    // gaps in RxSymValid
    lock("t5");
    step(3'd2, 1'b1, 1'b1);
    chk("t5_en0", deser_en, 1);
    chk("t5_ser0", ser_sym, 2);
    chk("t5_wp0", word_phase, 1);
    step(3'd6, 1'b0, 1'b1);
    chk("t5_en1", deser_en, 0);
    chk("t5_wp1", word_phase, 1);
    step(3'd5, 1'b1, 1'b1);
    chk("t5_en2", deser_en, 1);
    chk("t5_ser2", ser_sym, 5);
    chk("t5_wp2", word_phase, 2);
    step(3'd1, 1'b0, 1'b1);
    chk("t5_en3", deser_en, 0);
    chk("t5_wp3", word_phase, 2);

    // async reset mid-DATA at WordPhase 4
    step(3'd0, 1'b1, 1'b1);
    step(3'd1, 1'b1, 1'b1);
    chk("t6_wp_pre", word_phase, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_ser", ser_sym, 0);
    chk("t6_en", deser_en, 0);
    chk("t6_act", active, 0);
    chk("t6_wp", word_phase, 0);
    chk("t6_det", sync_det, 0);
    chk("t6_err", sync_err, 0);
    @(negedge clk);
    @(negedge clk);
    chk("t6_hold_en", deser_en, 0);
    rst_n = 1'b1;
    lock("t6");
    step(3'd6, 1'b1, 1'b1);
    chk("t6_ser_after", ser_sym, 6);
    chk("t6_wp_after", word_phase, 1);
    step(3'd0, 1'b0, 1'b1);
    step(3'd0, 1'b0, 1'b0);
    chk("t6_flush_start_act", active, 1);

    // long preamble saturates the counter and still locks
    for (int k = 0; k < 6; k++) step(3'd0, 1'b0, 1'b1);
    chk("sat_idle_act", active, 0);
    send_pre(13);
    lock("sat");
    step(3'd0, 1'b0, 1'b0);
    chk("sat_end_act", active, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/hs_sync_aligner.md
Name: hs_sync_aligner

Overview:
- Sits directly upstream of the HS deserializer in the C-PHY slave receive path, on the RxSymClkHS domain.
- Accepts recovered 3-bit symbols ({flip,rotation,polarity}) from clock/data recovery and hunts for the HS preamble followed by the sync word.
- Once sync is found, forwards payload symbols as SerSym with HSDeserEn strobes aligned so the deserializer's 7-symbol word boundary starts on the first payload symbol.
- At burst end, pads with zero symbols up to the next word boundary so the deserializer always returns to phase 0.

Parameters:
PRE_MIN, 7, minimum consecutive symbol-3 count accepted as a valid preamble before the sync word.
PRE_CNT_W, 4, width of the saturating preamble counter. Must satisfy 2^PRE_CNT_W-1 >= PRE_MIN.

Ports:
RxSymClkHS  in  1  HS symbol clock.
RstN  in  1  asynchronous active-low reset.
RxSymIn  in  3  recovered symbol {flip,rotation,polarity}.
RxSymValid  in  1  RxSymIn holds a new symbol this cycle.
HSRxEn  in  1  lane control: HS reception active. Deassertion marks end of burst.
SerSym  out  3  symbol to deserializer.
HSDeserEn  out  1  deserializer enable, one cycle per forwarded or pad symbol.
SyncDetected  out  1  one-cycle pulse: sync word accepted.
SyncErr  out  1  one-cycle pulse: sync word corrupted after a valid preamble.
RxActiveHS  out  1  high while in DATA or FLUSH.
WordPhase  out  3  index (0-6) of the next symbol within the current word.

Behaviour:
- Reset (async, RstN=0) clears all state and outputs:
  - State=IDLE.
  - SerSym=0, HSDeserEn=0, SyncDetected=0, SyncErr=0, RxActiveHS=0, WordPhase=0.
  - Preamble counter and sync index = 0.
- Reset may occur at any time, including mid-burst. No flush is performed; the deserializer is reset by the same RstN.
- All outputs are registered.
- Unless stated otherwise, a state advances only on edges where RxSymValid=1. Edges with RxSymValid=0 hold state and drive HSDeserEn=0.
- "3" means RxSymIn==3'b011; "4" means RxSymIn==3'b100.

State machine:
- IDLE:
  - HSRxEn=1 and valid 3 -> PREAMBLE, cnt=1.
  - Otherwise stay.
- PREAMBLE:
  - Valid 3 -> cnt+1, saturating at max.
  - Valid 4 with cnt>=PRE_MIN -> SYNC, idx=1.
  - Valid 4 with cnt<PRE_MIN -> IDLE, no error.
  - Any other valid symbol -> IDLE, cnt=0.
- SYNC: expects idx 2..6 = 4,4,4,4,3 (full sync word 3444443, leading 3 shared with the preamble).
  - Match at idx<6 -> idx+1.
  - Match at idx 6 -> DATA; SyncDetected=1 for one cycle on that edge; WordPhase=0.
  - Mismatch -> IDLE; SyncErr=1 for one cycle.
- DATA:
  - Each valid symbol -> SerSym<=RxSymIn, HSDeserEn<=1, WordPhase<=(WordPhase==6)?0:WordPhase+1.
  - Latency: 1 cycle from RxSymIn to SerSym.
  - The first symbol after the final sync 3 is word symbol 0.
- HSRxEn handling:
  - HSRxEn=0 in PREAMBLE or SYNC -> IDLE immediately; no error, no pulse.
  - HSRxEn=0 in DATA with WordPhase==0 -> IDLE.
  - HSRxEn=0 in DATA with WordPhase!=0 -> FLUSH. Any symbol presented that cycle is dropped.
  - If the final sync symbol and HSRxEn falling coincide, go to IDLE and suppress SyncDetected.
- FLUSH:
  - Ignores RxSymValid and HSRxEn.
  - Every cycle: SerSym<=0, HSDeserEn<=1, WordPhase advances.
  - When WordPhase wraps to 0 -> IDLE, HSDeserEn=0 next cycle.
  - Pad count = 7-WordPhase at entry.
- RxActiveHS = 1 in DATA and FLUSH, 0 otherwise.
- SyncDetected and SyncErr are never both 1 in the same cycle.

Test Plan:
1. Reset, HSRxEn=1, stream 7×3, then 4,4,4,4,4,3, then 14 data symbols 0..6,0..6 -> SyncDetected pulses once on the final-3 edge. HSDeserEn high 14 cycles starting one cycle after the first data symbol. SerSym follows the input with 1-cycle delay. WordPhase returns to 0 after 7 and after 14.
2. Only 5×3 then 4 -> back to IDLE, no SyncErr, HSDeserEn stays 0. Then a full 7×3 + sync word + data -> locks normally.
3. 8×3, 4,4,2 -> SyncErr one-cycle pulse, IDLE, no HSDeserEn. Subsequent valid preamble + sync locks.
4. Lock, 10 data symbols, drop HSRxEn with WordPhase=3 -> FLUSH drives 4 cycles of SerSym=0 with HSDeserEn=1, then IDLE, WordPhase=0, RxActiveHS=0.
5. In DATA, RxSymValid toggles 1,0,1,0 -> HSDeserEn follows 1,0,1,0 one cycle later. WordPhase advances only on valid symbols.
6. Assert RstN=0 mid-DATA at WordPhase=4 -> all outputs 0 immediately, no flush. After release, a new preamble + sync locks with WordPhase=0.
